stopwatch_ctrl: RTL and testbench

//   Consumes the one-cycle button pulses produced by the debouncers, together with the ADJ/SEL switches.

---
 rtl/stopwatch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause FSM, BCD time counter and adjust mode.
// Optional digit blinking in adjust mode is built when STOPWATCH_BLINK_EN is defined.
module stopwatch_ctrl #(
   parameter int MIN_LIMIT     = 60,
   parameter bit START_RUNNING = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pause_pulse,
   input  logic       reset_pulse,
   input  logic       adj,
   input  logic       sel,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       tick_blink,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic [3:0] blank
);

   localparam logic [0:0] PAUSED = 1'b0;
   localparam logic [0:0] RUN    = 1'b1;

   localparam logic [3:0] MAX_MT = 4'((MIN_LIMIT - 1) / 10);
   localparam logic [3:0] MAX_MO = 4'((MIN_LIMIT - 1) % 10);

   logic       adj_q;
   logic       adj_s;
   logic       sel_q;
   logic       sel_s;

   logic [0:0] state_q;
   logic [0:0] state_d;

   logic [3:0] mt_q;
   logic [3:0] mo_q;
   logic [3:0] st_q;
   logic [3:0] so_q;
   logic [3:0] mt_d;
   logic [3:0] mo_d;
   logic [3:0] st_d;
   logic [3:0] so_d;

   logic       run_tick;
   logic       adj_sec;
   logic       adj_min;
   logic       sec_last;
   logic       min_last;
   logic       sec_step;
   logic       min_step;

   // Switches are raw and asynchronous; two flops before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adj_q <= 1'b0;
         adj_s <= 1'b0;
         sel_q <= 1'b0;
         sel_s <= 1'b0;
      end else begin
         adj_q <= adj;
         adj_s <= adj_q;
         sel_q <= sel;
         sel_s <= sel_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PAUSED:  if (pause_pulse) state_d = RUN;
         RUN:     if (pause_pulse) state_d = PAUSED;
         default: state_d = PAUSED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= START_RUNNING ? RUN : PAUSED;
      end else begin
         state_q <= state_d;
      end
   end

   assign sec_last = (st_q == 4'd5) && (so_q == 4'd9);
   assign min_last = (mt_q == MAX_MT) && (mo_q == MAX_MO);

   assign run_tick = (state_q == RUN) && !adj_s && tick_1hz;
   assign adj_sec  = adj_s && sel_s && tick_2hz;
   assign adj_min  = adj_s && !sel_s && tick_2hz;

   // Adjust increments one field only; minutes carry only from a run tick.
   assign sec_step = run_tick || adj_sec;
   assign min_step = (run_tick && sec_last) || adj_min;

   always_comb begin
      st_d = st_q;
      so_d = so_q;
      if (reset_pulse) begin
         st_d = 4'd0;
         so_d = 4'd0;
      end else if (sec_step) begin
         if (so_q == 4'd9) begin
            so_d = 4'd0;
            st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
         end else begin
            so_d = so_q + 4'd1;
         end
      end
   end

   always_comb begin
      mt_d = mt_q;
      mo_d = mo_q;
      if (reset_pulse) begin
         mt_d = 4'd0;
         mo_d = 4'd0;
      end else if (min_step) begin
         if (min_last) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
         end else if (mo_q == 4'd9) begin
            mt_d = mt_q + 4'd1;
            mo_d = 4'd0;
         end else begin
            mo_d = mo_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mt_q <= 4'd0;
         mo_q <= 4'd0;
         st_q <= 4'd0;
         so_q <= 4'd0;
      end else begin
         mt_q <= mt_d;
         mo_q <= mo_d;
         st_q <= st_d;
         so_q <= so_d;
      end
   end

   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign running  = (state_q == RUN);

`ifdef STOPWATCH_BLINK_EN
   logic       phase_q;
   logic       phase_d;
   logic [3:0] blank_q;
   logic [3:0] blank_d;

   // Mask follows the new phase so blank and phase change on the same edge.
   always_comb begin
      phase_d = adj_s ? (phase_q ^ tick_blink) : 1'b0;
      blank_d = 4'b0000;
      if (phase_d) begin
         blank_d = sel_s ? 4'b0011 : 4'b1100;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         blank_q <= 4'b0000;
      end else begin
         phase_q <= phase_d;
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   logic unused_blink;

   assign unused_blink = tick_blink;
   assign blank        = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: reset, table vectors, corner sequences and
// random stimulus against a seconds-count reference model.
module tb_stopwatch_ctrl;

   localparam int ML = 60;
   localparam bit SR = 1'b0;

   logic       clk;
   logic       rst_n;
   logic       pause_pulse;
   logic       reset_pulse;
   logic       adj;
   logic       sel;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       tick_blink;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic [3:0] blank;

   int n_vec;
   int n_bad;

   int m_min;
   int m_sec;
   bit m_run;
   bit a_h0;
   bit a_h1;
   bit s_h0;
   bit s_h1;
   bit m_ph;
   int m_blank;

   typedef struct {
      bit pp;
      bit rp;
      bit a;
      bit s;
      bit t1;
      bit t2;
      int mm;
      int ss;
      bit run;
   } vec_t;

   vec_t tbl[22];

   stopwatch_ctrl #(
      .MIN_LIMIT    (ML),
      .START_RUNNING(SR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pause_pulse(pause_pulse),
      .reset_pulse(reset_pulse),
      .adj        (adj),
      .sel        (sel),
      .tick_1hz   (tick_1hz),
      .tick_2hz   (tick_2hz),
      .tick_blink (tick_blink),
      .min_tens   (min_tens),
      .min_ones   (min_ones),
      .sec_tens   (sec_tens),
      .sec_ones   (sec_ones),
      .running    (running),
      .blank      (blank)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int dmin();
      return int'(min_tens) * 10 + int'(min_ones);
   endfunction

   function automatic int dsec();
      return int'(sec_tens) * 10 + int'(sec_ones);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_min   = 0;
      m_sec   = 0;
      m_run   = SR;
      a_h0    = 1'b0;
      a_h1    = 1'b0;
      s_h0    = 1'b0;
      s_h1    = 1'b0;
      m_ph    = 1'b0;
      m_blank = 0;
   endtask

   // One clock of the reference: time kept as plain minutes and seconds.
   task automatic model_edge(input bit pp, rp, a, s, t1, t2, tb);
      bit a_s;
      bit s_s;
      int tot;
      a_s  = a_h1;
      s_s  = s_h1;
      a_h1 = a_h0;
      a_h0 = a;
      s_h1 = s_h0;
      s_h0 = s;
      if (rp) begin
         m_min = 0;
         m_sec = 0;
      end else if (a_s) begin
         if (t2 && s_s) m_sec = (m_sec + 1) % 60;
         if (t2 && !s_s) m_min = (m_min + 1) % ML;
      end else if (m_run && t1) begin
         tot   = (m_min * 60 + m_sec + 1) % (ML * 60);
         m_min = tot / 60;
         m_sec = tot % 60;
      end
      if (pp) m_run = !m_run;
`ifdef STOPWATCH_BLINK_EN
      if (!a_s) m_ph = 1'b0;
      else if (tb) m_ph = !m_ph;
      m_blank = m_ph ? (s_s ? 3 : 12) : 0;
`else
      m_blank = 0;
      if (tb) m_ph = m_ph;
`endif
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".min_tens"}, int'(min_tens), m_min / 10);
      chk({tag, ".min_ones"}, int'(min_ones), m_min % 10);
      chk({tag, ".sec_tens"}, int'(sec_tens), m_sec / 10);
      chk({tag, ".sec_ones"}, int'(sec_ones), m_sec % 10);
      chk({tag, ".running"}, int'(running), int'(m_run));
      chk({tag, ".blank"}, int'(blank), m_blank);
   endtask

   task automatic step(input bit pp, rp, a, s, t1, t2, tb);
      pause_pulse = pp;
      reset_pulse = rp;
      adj         = a;
      sel         = s;
      tick_1hz    = t1;
      tick_2hz    = t2;
      tick_blink  = tb;
      @(posedge clk);
      model_edge(pp, rp, a, s, t1, t2, tb);
      #1;
      check_all("step");
   endtask

   task automatic do_reset();
      pause_pulse = 1'b0;
      reset_pulse = 1'b0;
      adj         = 1'b0;
      sel         = 1'b0;
      tick_1hz    = 1'b0;
      tick_2hz    = 1'b0;
      tick_blink  = 1'b0;
      rst_n       = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      #3;
      rst_n = 1'b1;
   endtask

   task automatic idle(input bit a, s, input int n);
      for (int i = 0; i < n; i++) step(0, 0, a, s, 0, 0, 0);
   endtask

   task automatic t2s(input bit s, input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, s, 0, 1, 0);
   endtask

   task automatic t1s(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic set_row(input int i, input bit pp, rp, a, s, t1, t2,
                          input int mm, ss, input bit run);
      tbl[i] = '{pp, rp, a, s, t1, t2, mm, ss, run};
   endtask

   initial begin
      bit ca;
      bit cs;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b1;
      pause_pulse = 1'b0;
      reset_pulse = 1'b0;
      adj = 1'b0;
      sel = 1'b0;
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      tick_blink = 1'b0;

      set_row(0,  1, 0, 0, 0, 0, 0, 0, 0, 1);
      set_row(1,  0, 0, 0, 0, 1, 0, 0, 1, 1);
      set_row(2,  0, 0, 0, 0, 1, 0, 0, 2, 1);
      set_row(3,  1, 0, 0, 0, 0, 0, 0, 2, 0);
      set_row(4,  0, 0, 0, 0, 1, 0, 0, 2, 0);
      set_row(5,  1, 0, 0, 0, 1, 0, 0, 2, 1);
      set_row(6,  0, 0, 0, 0, 1, 0, 0, 3, 1);
      set_row(7,  0, 1, 0, 0, 1, 0, 0, 0, 1);
      set_row(8,  1, 1, 0, 0, 0, 0, 0, 0, 0);
      set_row(9,  0, 0, 0, 0, 0, 1, 0, 0, 0);
      set_row(10, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      set_row(11, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      set_row(12, 0, 0, 1, 1, 0, 1, 0, 1, 0);
      set_row(13, 0, 0, 1, 1, 1, 0, 0, 1, 0);
      set_row(14, 1, 0, 1, 1, 1, 0, 0, 1, 1);
      set_row(15, 0, 0, 1, 1, 1, 0, 0, 1, 1);
      set_row(16, 0, 0, 1, 0, 0, 1, 0, 2, 1);
      set_row(17, 0, 0, 1, 0, 0, 1, 0, 3, 1);
      set_row(18, 0, 0, 1, 0, 0, 1, 1, 3, 1);
      set_row(19, 0, 0, 0, 0, 1, 0, 1, 3, 1);
      set_row(20, 0, 0, 0, 0, 1, 0, 1, 3, 1);
      set_row(21, 0, 0, 0, 0, 1, 0, 1, 4, 1);

      #1 rst_n = 1'b0;
      #2;
      chk("por_min", dmin(), 0);
      chk("por_sec", dsec(), 0);
      chk("por_run", int'(running), int'(SR));
      chk("por_blank", int'(blank), 0);

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].pp, tbl[i].rp, tbl[i].a, tbl[i].s,
              tbl[i].t1, tbl[i].t2, 1'b0);
         chk($sformatf("tbl%0d_min", i), dmin(), tbl[i].mm);
         chk($sformatf("tbl%0d_sec", i), dsec(), tbl[i].ss);
         chk($sformatf("tbl%0d_run", i), int'(running), int'(tbl[i].run));
      end

      // 61 s of running from 00:00
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      t1s(61);
      chk("run61_min", dmin(), 1);
      chk("run61_sec", dsec(), 1);
      chk("run61_run", int'(running), 1);

      // preload 59:59, then one run tick wraps the whole display
      do_reset();
      idle(1, 0, 2);
      t2s(0, 59);
      idle(1, 1, 2);
      t2s(1, 59);
      chk("pre_min", dmin(), 59);
      chk("pre_sec", dsec(), 59);
      idle(0, 0, 2);
      step(1, 0, 0, 0, 0, 0, 0);
      t1s(1);
      chk("wrap_min", dmin(), 0);
      chk("wrap_sec", dsec(), 0);

      // paused ignores ticks
      t1s(3);
      step(1, 0, 0, 0, 0, 0, 0);
      t1s(5);
      chk("pause_sec", dsec(), 3);
      chk("pause_run", int'(running), 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("resume_run", int'(running), 1);

      // minute adjust wraps at the limit
      do_reset();
      idle(1, 0, 2);
      t2s(0, ML);
      chk("madj_wrap", dmin(), 0);
      t2s(0, 1);
      chk("madj_next", dmin(), 1);

      // seconds adjust without carry, then minutes
      do_reset();
      idle(1, 1, 2);
      t2s(1, 58);
      t2s(1, 3);
      chk("sadj_sec", dsec(), 1);
      chk("sadj_min", dmin(), 0);
      idle(1, 0, 2);
      t2s(0, 2);
      chk("madj_min", dmin(), 2);
      chk("madj_sec", dsec(), 1);

      // reset_pulse beats a tick; pause still toggles
      do_reset();
      idle(1, 0, 2);
      t2s(0, 12);
      idle(1, 1, 2);
      t2s(1, 34);
      idle(0, 0, 2);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("pre1234_min", dmin(), 12);
      chk("pre1234_sec", dsec(), 34);
      step(1, 1, 0, 0, 1, 0, 0);
      chk("clr_min", dmin(), 0);
      chk("clr_sec", dsec(), 0);
      chk("clr_run", int'(running), 0);

      // async reset in the middle of counting
      step(1, 0, 0, 0, 0, 0, 0);
      t1s(7);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_sec", dsec(), 0);
      chk("arst_run", int'(running), int'(SR));
      #1 rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0);
      t1s(2);
      chk("arst_resume", dsec(), 2);

`ifdef STOPWATCH_BLINK_EN
      do_reset();
      idle(1, 0, 2);
      step(0, 0, 1, 0, 0, 0, 1);
      chk("blink1", int'(blank), 12);
      step(0, 0, 1, 0, 0, 0, 1);
      chk("blink2", int'(blank), 0);
      step(0, 0, 1, 0, 0, 0, 1);
      idle(0, 0, 3);
      chk("blink_off", int'(blank), 0);
`endif

      // random traffic against the model
      do_reset();
      ca = 1'b0;
      cs = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) ca = !ca;
         if ($urandom_range(19) == 0) cs = !cs;
         step($urandom_range(7) == 0, $urandom_range(31) == 0, ca, cs,
              $urandom_range(2) == 0, $urandom_range(2) == 0,
              $urandom_range(3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
